// File: rtl/rom_angle_burst_sched_if.sv
// rom_angle_burst_sched_if
//   Bundles the request, ROM and output-stream signals of rom_angle_burst_sched.
//   slave  : scheduler view (accepts requests, drives the ROM port and the beat stream)
//   master : environment view (requesters, ROM model, stream consumer)
//   req_valid/req_ready/req_start/req_len : per-requester burst request handshake
//   rom_enable/rom_address/rom_dout       : single-port ROM, 1-cycle registered read
//   out_valid/out_ready/out_data/out_id/out_last : beat stream to the consumer
//   busy                                  : scheduler not idle
interface rom_angle_burst_sched_if #(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 21,
  parameter int NUM_REQ   = 2
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int LW = $clog2(MEM_DEPTH + 1);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_start;
  logic [NUM_REQ*LW-1:0] req_len;
  logic                  rom_enable;
  logic [AW-1:0]         rom_address;
  logic [MEM_WIDTH-1:0]  rom_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [MEM_WIDTH-1:0]  out_data;
  logic [IW-1:0]         out_id;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  req_valid, req_start, req_len, rom_dout, out_ready,
    output req_ready, rom_enable, rom_address, out_valid, out_data, out_id, out_last, busy
  );

  modport master (
    output req_valid, req_start, req_len, rom_dout, out_ready,
    input  req_ready, rom_enable, rom_address, out_valid, out_data, out_id, out_last, busy
  );
endinterface

// File: rtl/rom_angle_burst_sched.sv
// rom_angle_burst_sched
//   Round-robin scheduler sharing one single-port angle ROM among NUM_REQ
//   requesters. A grant runs a burst of consecutive reads (wrapping modulo
//   MEM_DEPTH); each beat is returned with its requester id and a last flag
//   under valid/ready.
//   clock : single clock, posedge
//   reset : synchronous, active-high
//   bus   : rom_angle_burst_sched_if.slave (requests, ROM port, beat stream, busy)
module rom_angle_burst_sched #(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 21,
  parameter int NUM_REQ   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  rom_angle_burst_sched_if.slave   bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int LW = $clog2(MEM_DEPTH + 1);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [IW-1:0]   id_q, id_d;
  logic            out_valid_q, out_valid_d;
  logic [IW-1:0]   out_id_q, out_id_d;
  logic            out_last_q, out_last_d;

  logic [AW-1:0]      start_arr [NUM_REQ];
  logic [LW-1:0]      len_arr   [NUM_REQ];
  logic               grant_found;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      cand;
  logic [NUM_REQ-1:0] grant_oh;
  logic [AW-1:0]      start_sel;
  logic [LW-1:0]      len_sel;
  logic               issue;
  logic               issue_last;

  // Unpack the per-requester fields so they can be indexed by requester id.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      start_arr[r] = bus.req_start[r*AW +: AW];
      len_arr[r]   = bus.req_len[r*LW +: LW];
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((32'(rr_ptr_q) + i) % 32'(NUM_REQ));
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  always_comb begin
    start_sel = start_arr[grant_idx];
    if (32'(start_sel) >= 32'(MEM_DEPTH)) begin
      start_sel = start_sel - AW'(MEM_DEPTH);
    end
    len_sel = len_arr[grant_idx];
    if (len_sel == '0) begin
      len_sel = LW'(MEM_DEPTH);
    end
  end

  // A read may only be issued if the output register is free on the next
  // cycle, since the ROM register and out_valid advance together.
  assign issue      = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign issue_last = (rem_q == LW'(1));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d  = RUN;
          rr_ptr_d = grant_idx;
          id_d     = grant_idx;
          addr_d   = start_sel;
          rem_d    = len_sel;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = (addr_q == AW'(MEM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
          if (issue_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      out_valid_d = 1'b1;
      out_id_d    = id_q;
      out_last_d  = issue_last;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IW'(NUM_REQ - 1);
      addr_q      <= '0;
      rem_q       <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE && grant_found) ? grant_oh : '0;
  assign bus.rom_enable  = issue;
  assign bus.rom_address = addr_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = bus.rom_dout;
  assign bus.out_id      = out_id_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = (state_q != IDLE);
endmodule
